// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared limits and types for the multi-channel clock divider.
// Optional feature macro: CLK_DIV_DUTY50_EN (50% duty for odd divisors).
package clk_div_pkg;

  // Legal parameter ranges for clk_div_multi.
  localparam int CH_MIN   = 1;
  localparam int CH_MAX   = 16;
  localparam int WIDE_MIN = 2;
  localparam int WIDE_MAX = 32;

  // Smallest divisor that starts a channel; zero means "stop".
  localparam int DIV_MIN  = 1;

  // What a channel does on the coming rising edge.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,  // idle and not starting
    ACT_COUNT = 2'd1,  // running, mid-period
    ACT_LOAD  = 2'd2,  // adopt i_Div, restart at Cnt=0, pulse o_Load
    ACT_STOP  = 2'd3   // clear run, hold output low
  } ch_action_e;

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel. Counts 0..D-1, base output high for the
// first floor(D/2) counts, tick while Cnt==0, and o_Load pulses on every
// load point (start, reload at wrap, sync restart). D=1 bypasses to clk.
// Macro CLK_DIV_DUTY50_EN adds a falling-edge flop that stretches the high
// phase of odd divisors (D>=3) by half an input period.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int WIDE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [WIDE-1:0] div,
  input  logic            sync,
  output logic            clk_out,
  output logic            tick,
  output logic            load
);

  localparam logic [WIDE-1:0] ONE  = WIDE'(1);
  localparam logic [WIDE-1:0] DMIN = WIDE'(DIV_MIN);

  logic [WIDE-1:0] cnt_q, cnt_d;
  logic [WIDE-1:0] act_div_q, act_div_d;
  logic            run_q, run_d;
  logic            base_q, base_d;
  logic            tick_q, tick_d;
  logic            load_q, load_d;
  logic            bypass_q, bypass_d;

  logic            div_ok;
  logic            at_wrap;
  ch_action_e      action;

  assign div_ok  = (div >= DMIN);
  assign at_wrap = (cnt_q == act_div_q - ONE);

  // Decide the channel action; sync beats wrap and blocks an idle start.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    action = ACT_HOLD;
    if (run_q) begin
      if (sync) begin
        action = div_ok ? ACT_LOAD : ACT_STOP;
      end else if (at_wrap) begin
        action = (en && div_ok) ? ACT_LOAD : ACT_STOP;
      end else begin
        action = ACT_COUNT;
      end
    end else if (!sync && en && div_ok) begin
      action = ACT_LOAD;
    end
  end

  // Next-state values and the registered-output decodes of that next state.
  always_comb begin
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    run_d     = run_q;
    load_d    = 1'b0;
    case (action)
      ACT_COUNT: cnt_d = cnt_q + ONE;
      ACT_LOAD: begin
        cnt_d     = '0;
        act_div_d = div;
        run_d     = 1'b1;
        load_d    = 1'b1;
      end
      ACT_STOP: begin
        cnt_d     = '0;
        act_div_d = '0;
        run_d     = 1'b0;
      end
      default: ;
    endcase
    tick_d   = run_d && (cnt_d == '0);
    base_d   = run_d && (cnt_d < (act_div_d >> 1));
    bypass_d = run_d && (act_div_d == ONE);
  end

  // Rising-edge state: counter, divisor, run flag and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      act_div_q <= '0;
      run_q     <= 1'b0;
      base_q    <= 1'b0;
      tick_q    <= 1'b0;
      load_q    <= 1'b0;
      bypass_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      run_q     <= run_d;
      base_q    <= base_d;
      tick_q    <= tick_d;
      load_q    <= load_d;
      bypass_q  <= bypass_d;
    end
  end

  assign tick = tick_q;
  assign load = load_q;

`ifdef CLK_DIV_DUTY50_EN
  logic odd_q, odd_d;
  logic neg_q, neg_d;

  // Odd-divisor select (D>=3) and the half-cycle delayed copy of the base output.
  always_comb begin
    odd_d = run_d && act_div_d[0] && (act_div_d != ONE);
    neg_d = base_q;
  end

  // Odd-divisor select, changing only at load points like the bypass select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_q <= 1'b0;
    end else begin
      odd_q <= odd_d;
    end
  end

  // Falling-edge re-sample of the base output; extends the high phase by half a cycle.
  // NOTE: this flop also takes the async reset so o_Clk drops at once when reset asserts.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign clk_out = base_q | (neg_q & odd_q) | (bypass_q & clk);
`else
  assign clk_out = base_q | (bypass_q & clk);
`endif

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: CH independent clock dividers sharing one clock, reset and
// phase-restart strobe. Divisor of channel k is i_Div[k*WIDE +: WIDE].
// Optional feature macro: CLK_DIV_DUTY50_EN (50% duty for odd divisors).
// Legal ranges: CH in clk_div_pkg::CH_MIN..CH_MAX, WIDE in WIDE_MIN..WIDE_MAX.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH   = 4,
  parameter int WIDE = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [CH-1:0]        i_En,
  input  logic [CH*WIDE-1:0]   i_Div,
  input  logic                 i_Sync,
  output logic [CH-1:0]        o_Clk,
  output logic [CH-1:0]        o_Tick,
  output logic [CH-1:0]        o_Load
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    clk_div_ch #(
      .WIDE (WIDE)
    ) u_ch (
      .clk     (i_Clk),
      .rst_n   (i_Rst_n),
      .en      (i_En[k]),
      .div     (i_Div[k*WIDE +: WIDE]),
      .sync    (i_Sync),
      .clk_out (o_Clk[k]),
      .tick    (o_Tick[k]),
      .load    (o_Load[k])
    );
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDE, default 16, divisor width per channel (2..32).
REQ-003 SHALL have port i_Clk, input, 1, sole clock; all state on rising edge except the duty-correction flop (REQ-022).
REQ-004 SHALL have port i_Rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_En, input, CH, per-channel run request.
REQ-006 SHALL have port i_Div, input, CH*WIDE, packed divisors; channel k uses bits [k*WIDE +: WIDE].
REQ-007 SHALL have port i_Sync, input, 1, synchronous phase-restart strobe for all channels.
REQ-008 SHALL have port o_Clk, output, CH, divided clocks.
REQ-009 SHALL have port o_Tick, output, CH, one-cycle pulse per output period.
REQ-010 SHALL have port o_Load, output, CH, one-cycle pulse when a channel adopts a new divisor.

Function
REQ-011 Each channel SHALL hold a counter Cnt[WIDE-1:0], an active divisor ActDiv, and a run flag.
REQ-012 Idle channel: when i_En[k]=1 and i_Div[k]>=1, it SHALL load ActDiv=i_Div[k] and Cnt=0, set run, and pulse o_Load[k], all on the same edge.
REQ-013 Running with ActDiv=D>=2: Cnt SHALL count 0..D-1 and then wrap to 0.
REQ-014 Running with D>=2, the base output SHALL be high while Cnt < floor(D/2) and low otherwise.
REQ-015 o_Tick[k] SHALL be registered and high for exactly the cycle in which Cnt==0, giving one pulse per D cycles.
REQ-016 New i_Div values SHALL take effect only at wrap (Cnt==D-1 edge); the load and o_Load pulse SHALL occur there, and mid-period changes SHALL be ignored.
REQ-017 If i_En[k]=0 at wrap, the channel SHALL clear run and hold o_Clk low; deassertion mid-period SHALL complete the current period, so there are no runt pulses.
REQ-018 A divisor of 0 sampled at load SHALL be treated as a stop: run cleared, output low.
REQ-019 ActDiv=1 SHALL route i_Clk to o_Clk[k] through a mux whose select changes only at a load point, and o_Tick[k] SHALL then be held high.
REQ-020 i_Sync=1 SHALL force every running channel to Cnt=0 and reload ActDiv on that edge, with o_Load pulsing; i_Sync SHALL override wrap and i_En start for that cycle.
REQ-021 The counter compare SHALL be WIDE bits unsigned, with no overflow for D=2^WIDE-1.

Reset
REQ-022 While i_Rst_n=0, Cnt, ActDiv, run, the negedge flop, o_Clk, o_Tick and o_Load SHALL all be 0 immediately, without waiting for a clock edge.
REQ-023 After reset release, no channel SHALL start before the first rising edge with i_En[k]=1.
REQ-024 Reset asserted mid-period SHALL drop o_Clk low asynchronously, and the channel SHALL restart per REQ-012.

Configuration
REQ-025 Macro CLK_DIV_DUTY50_EN defined: for odd D>=3, a falling-edge flop SHALL re-sample the base output, and o_Clk SHALL be the OR of the base output and that flop, giving a high time of D/2 input periods (50% duty).
REQ-026 Macro CLK_DIV_DUTY50_EN undefined: no falling-edge logic SHALL exist, and odd D SHALL give high time floor(D/2) cycles.
REQ-027 Even D SHALL be identical with and without the macro.

Structure
REQ-028 Package clk_div_pkg SHALL hold the CH and WIDE limits and a localparam for the minimum divider value.
REQ-029 Sub-module clk_div_ch SHALL implement one channel; clk_div_multi SHALL instantiate CH copies in a generate loop and share i_Sync across them.

Verification
REQ-030 Bench SHALL cover: i_Div[0]=4, i_En[0]=1 -> o_Clk[0] with period 4, 2 high / 2 low, and o_Tick every 4 cycles.
REQ-031 Bench SHALL cover: i_Div[1]=5, macro on -> high 2.5 cycles, period 5; macro off -> high 2, low 3.
REQ-032 Bench SHALL cover: i_Div[2] changed 6->3 at Cnt=2 -> remaining period stays 6, o_Load at wrap, then period 3.
REQ-033 Bench SHALL cover: i_En[3] dropped at Cnt=1 with D=8 -> period completes and output then stays low; i_Div=1 -> o_Clk equals i_Clk.
REQ-034 Bench SHALL cover: channels with D=3 and D=7, i_Sync pulsed -> both o_Tick pulse on the next cycle, in phase.
REQ-035 Bench SHALL cover: i_Rst_n pulsed low between clock edges mid-high phase -> all outputs go 0 immediately.
